// File: rtl/move_input_conditioner_if.sv
// Raw switch inputs and conditioned pulse/level outputs of move_input_conditioner.
interface move_input_conditioner_if;
  logic i_Switch_Up;
  logic i_Switch_Down;
  logic i_Switch_Left;
  logic i_Switch_Right;
  logic i_Switch_Start;
  logic o_Up_Mvt;
  logic o_Down_Mvt;
  logic o_Left_Mvt;
  logic o_Right_Mvt;
  logic o_Game_Start;
  logic o_Any_Held;

  modport master (
    output i_Switch_Up, i_Switch_Down, i_Switch_Left, i_Switch_Right, i_Switch_Start,
    input  o_Up_Mvt, o_Down_Mvt, o_Left_Mvt, o_Right_Mvt, o_Game_Start, o_Any_Held
  );

  modport slave (
    input  i_Switch_Up, i_Switch_Down, i_Switch_Left, i_Switch_Right, i_Switch_Start,
    output o_Up_Mvt, o_Down_Mvt, o_Left_Mvt, o_Right_Mvt, o_Game_Start, o_Any_Held
  );
endinterface

// File: rtl/move_input_conditioner.sv
// Synchronise + debounce 4 direction switches and start; emit one-cycle press pulses (press at edge 3+DEBOUNCE_CYCLES).
// Optional hold-to-repeat of the owning direction under MOVE_AUTO_REPEAT_EN; no backpressure, losing presses dropped.
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 7500000,
  parameter int REPEAT_RATE     = 2500000
) (
  input logic                      i_Clk,
  input logic                      i_Rst,
  move_input_conditioner_if.slave  io
);

  localparam int NIN = 5;
  localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // Bit order: 0 Up, 1 Down, 2 Left, 3 Right, 4 Start (low index = higher priority).
  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1_q, sync2_q;
  logic [NIN-1:0] stable_q, stable_d;
  logic [NIN-1:0] prev_q;
  logic [NIN-1:0] press;
  logic [DW-1:0]  db_cnt_q [NIN];
  logic [DW-1:0]  db_cnt_d [NIN];
  logic [3:0]     win_oh;
  logic [3:0]     mvt_q, mvt_d;
  logic           start_q;
  logic           any_q;

  assign raw = {io.i_Switch_Start, io.i_Switch_Right, io.i_Switch_Left,
                io.i_Switch_Down, io.i_Switch_Up};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NIN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign press = stable_q & ~prev_q;

  always_comb begin
    win_oh = '0;
    if (press[0])      win_oh = 4'b0001;
    else if (press[1]) win_oh = 4'b0010;
    else if (press[2]) win_oh = 4'b0100;
    else if (press[3]) win_oh = 4'b1000;
  end

`ifdef MOVE_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;

  rpt_state_e     state_q, state_d;
  logic [1:0]     owner_q, owner_d;
  logic [1:0]     win_idx;
  logic [RW-1:0]  rcnt_q, rcnt_d;
  logic [RW-1:0]  rlast;

  assign win_idx = {win_oh[3] | win_oh[2], win_oh[3] | win_oh[1]};

  // A fresh press always wins over release and over a same-cycle repeat expiry.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rcnt_d  = rcnt_q;
    mvt_d   = '0;
    rlast   = (state_q == DELAY) ? DELAY_LAST : RATE_LAST;
    if (|win_oh) begin
      mvt_d   = win_oh;
      owner_d = win_idx;
      rcnt_d  = '0;
      state_d = DELAY;
    end else if (state_q != IDLE) begin
      if (!stable_q[owner_q]) begin
        state_d = IDLE;
        rcnt_d  = '0;
      end else if (rcnt_q == rlast) begin
        mvt_d   = 4'b0001 << owner_q;
        rcnt_d  = '0;
        state_d = REPEAT;
      end else begin
        rcnt_d  = rcnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rcnt_q  <= rcnt_d;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
  assign mvt_d = win_oh;
`endif

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      for (int i = 0; i < NIN; i++) db_cnt_q[i] <= '0;
      mvt_q    <= '0;
      start_q  <= 1'b0;
      any_q    <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      for (int i = 0; i < NIN; i++) db_cnt_q[i] <= db_cnt_d[i];
      mvt_q    <= mvt_d;
      start_q  <= press[4];
      any_q    <= |stable_q[3:0];
    end
  end

  assign io.o_Up_Mvt     = mvt_q[0];
  assign io.o_Down_Mvt   = mvt_q[1];
  assign io.o_Left_Mvt   = mvt_q[2];
  assign io.o_Right_Mvt  = mvt_q[3];
  assign io.o_Game_Start = start_q;
  assign io.o_Any_Held   = any_q;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed + random bench for move_input_conditioner against a window-based debounce and due-time repeat model.
module tb_move_input_conditioner;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam int HL = D + 2;
`ifdef MOVE_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk;
  logic rst;
  move_input_conditioner_if bus();

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dut_pulses = 0;

  // Model state: raw sample history per input (index 0 = newest edge).
  bit         rawh [5][HL];
  logic [4:0] m_stable;
  logic [4:0] m_prev;
  int         m_owner;
  int         m_due;
  int         n;
  logic [3:0] exp_mvt;
  logic       exp_start;
  logic       exp_any;

  logic [3:0] mvt_obs;
  logic [7:0] all_obs;
  assign mvt_obs = {bus.o_Right_Mvt, bus.o_Left_Mvt, bus.o_Down_Mvt, bus.o_Up_Mvt};
  assign all_obs = {2'b00, bus.o_Game_Start, bus.o_Any_Held, mvt_obs};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < HL; k++) rawh[i][k] = 1'b0;
    m_stable  = '0;
    m_prev    = '0;
    m_owner   = -1;
    m_due     = 0;
    n         = 0;
    exp_mvt   = '0;
    exp_start = 1'b0;
    exp_any   = 1'b0;
  endtask

  // Expected outputs after the coming edge, given the raw inputs sampled at it.
  task automatic model_step(input logic [4:0] raw);
    logic [4:0] press;
    int win;
    bit all_diff;
    n++;
    press     = m_stable & ~m_prev;
    exp_any   = |m_stable[3:0];
    exp_start = press[4];
    exp_mvt   = '0;
    win = -1;
    for (int i = 3; i >= 0; i--) if (press[i]) win = i;
    if (win >= 0) begin
      exp_mvt[win] = 1'b1;
      m_owner = win;
      m_due   = n + RD;
    end else if (AUTO && m_owner >= 0) begin
      if (!m_stable[m_owner]) begin
        m_owner = -1;
      end else if (n == m_due) begin
        exp_mvt[m_owner] = 1'b1;
        m_due = n + RR;
      end
    end
    m_prev = m_stable;
    for (int i = 0; i < 5; i++) begin
      for (int k = HL - 1; k > 0; k--) rawh[i][k] = rawh[i][k-1];
      rawh[i][0] = raw[i];
      // Level accepted once the last D synchronised samples all disagree with it.
      all_diff = 1'b1;
      for (int k = 2; k < D + 2; k++) if (rawh[i][k] == m_stable[i]) all_diff = 1'b0;
      if (all_diff) m_stable[i] = ~m_stable[i];
    end
  endtask

  task automatic set_sw(input logic [4:0] v);
    bus.i_Switch_Up    = v[0];
    bus.i_Switch_Down  = v[1];
    bus.i_Switch_Left  = v[2];
    bus.i_Switch_Right = v[3];
    bus.i_Switch_Start = v[4];
  endtask

  task automatic tick();
    model_step({bus.i_Switch_Start, bus.i_Switch_Right, bus.i_Switch_Left,
                bus.i_Switch_Down, bus.i_Switch_Up});
    @(posedge clk);
    @(negedge clk);
    dut_pulses += $countones(mvt_obs) + int'(bus.o_Game_Start);
    chk($sformatf("mvt@%0d", n), {4'b0, mvt_obs}, {4'b0, exp_mvt});
    chk($sformatf("start@%0d", n), {7'b0, bus.o_Game_Start}, {7'b0, exp_start});
    chk($sformatf("any@%0d", n), {7'b0, bus.o_Any_Held}, {7'b0, exp_any});
    chk($sformatf("onehot@%0d", n), {7'b0, ($countones(mvt_obs) <= 1)}, 8'h01);
  endtask

  task automatic run_to(input int e);
    while (n < e) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async", all_obs, 8'h00);
    model_clear();
    dut_pulses = 0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold", all_obs, 8'h00);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    set_sw(5'b00000);
    model_clear();

    // 1: single Up press, held 10 cycles
    do_reset();
    set_sw(5'b00001);
    run_to(6);  chk("t1_up_e6", {7'b0, bus.o_Up_Mvt}, 8'h00);
    run_to(7);  chk("t1_up_e7", {7'b0, bus.o_Up_Mvt}, 8'h01);
    run_to(10); set_sw(5'b00000);
    run_to(30); chk("t1_pulses", 8'(dut_pulses), 8'd1);

    // 2: Right bouncing 3 high / 3 low
    do_reset();
    for (int r = 0; r < 5; r++) begin
      set_sw(5'b01000); run_to(n + 3);
      set_sw(5'b00000); run_to(n + 3);
    end
    run_to(n + 10);
    chk("t2_pulses", 8'(dut_pulses), 8'd0);

    // 3: Up and Left together
    do_reset();
    set_sw(5'b00101);
    run_to(6);  chk("t3_any_e6", {7'b0, bus.o_Any_Held}, 8'h00);
    run_to(7);
    chk("t3_up_e7", {7'b0, bus.o_Up_Mvt}, 8'h01);
    chk("t3_left_e7", {7'b0, bus.o_Left_Mvt}, 8'h00);
    chk("t3_any_e7", {7'b0, bus.o_Any_Held}, 8'h01);
    run_to(12); set_sw(5'b00000);
    run_to(30);

    // 4: Down held 60 cycles
    do_reset();
    set_sw(5'b00010);
    run_to(7);  chk("t4_down_e7", {7'b0, bus.o_Down_Mvt}, 8'h01);
    run_to(26); chk("t4_down_e26", {7'b0, bus.o_Down_Mvt}, 8'h00);
    run_to(27); chk("t4_down_e27", {7'b0, bus.o_Down_Mvt}, {7'b0, AUTO});
    run_to(35); chk("t4_down_e35", {7'b0, bus.o_Down_Mvt}, {7'b0, AUTO});
    run_to(59); chk("t4_down_e59", {7'b0, bus.o_Down_Mvt}, {7'b0, AUTO});
    run_to(60); set_sw(5'b00000);
    run_to(67); chk("t4_down_e67", {7'b0, bus.o_Down_Mvt}, 8'h00);
    run_to(80); chk("t4_pulses", 8'(dut_pulses), AUTO ? 8'd6 : 8'd1);

    // 5: Right takes ownership from repeating Left
    do_reset();
    set_sw(5'b00100);
    run_to(29); set_sw(5'b01100);
    run_to(35); chk("t5_left_e35", {7'b0, bus.o_Left_Mvt}, {7'b0, AUTO});
    run_to(36); chk("t5_right_e36", {7'b0, bus.o_Right_Mvt}, 8'h01);
    run_to(43); chk("t5_left_e43", {7'b0, bus.o_Left_Mvt}, 8'h00);
    run_to(56); chk("t5_right_e56", {7'b0, bus.o_Right_Mvt}, {7'b0, AUTO});
    run_to(64); chk("t5_right_e64", {7'b0, bus.o_Right_Mvt}, {7'b0, AUTO});
    set_sw(5'b00000);
    run_to(80);

    // 6: reset mid-repeat with Down still held
    do_reset();
    set_sw(5'b00010);
    run_to(40);
    do_reset();
    run_to(6); chk("t6_down_e6", {7'b0, bus.o_Down_Mvt}, 8'h00);
    run_to(7); chk("t6_down_e7", {7'b0, bus.o_Down_Mvt}, 8'h01);
    set_sw(5'b00000);
    run_to(30);

    // Random hold patterns, including start
    do_reset();
    for (int s = 0; s < 40; s++) begin
      logic [4:0] v;
      for (int b = 0; b < 5; b++) v[b] = ($urandom_range(0, 2) == 0);
      set_sw(v);
      run_to(n + int'($urandom_range(1, 30)));
    end
    set_sw(5'b00000);
    run_to(n + 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/move_input_conditioner.md
# move_input_conditioner

Conditions the four raw direction switches and the start switch of the Go Board before they reach the game top level. Each input is synchronised and debounced. Each debounced press becomes a single-cycle pulse on the `o_*_Mvt` / `o_Game_Start` outputs, and these drive the game's `i_*_Mvt` / `i_Game_Start` inputs directly. An optional auto-repeat engine re-issues the move pulse while a direction is held.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required to accept a level change (10 ms at 25 MHz).
- `REPEAT_DELAY`, default 7500000: held cycles before the first repeat pulse (300 ms).
- `REPEAT_RATE`, default 2500000: cycles between subsequent repeat pulses (100 ms).

Ports:
- `i_Clk`, in, 1: system clock, 25 MHz.
- `i_Rst`, in, 1: reset; asynchronous, active-high.
- `i_Switch_Up`, `i_Switch_Down`, `i_Switch_Left`, `i_Switch_Right`, in, 1 each: raw switches, active-high, asynchronous to `i_Clk`.
- `i_Switch_Start`, in, 1: raw start switch, active-high.
- `o_Up_Mvt`, `o_Down_Mvt`, `o_Left_Mvt`, `o_Right_Mvt`, out, 1 each: one-cycle move pulses, registered.
- `o_Game_Start`, out, 1: one-cycle pulse per debounced start press, registered.
- `o_Any_Held`, out, 1: OR of the four debounced direction levels, registered.

## Operation
- **Synchroniser:** two-flop synchroniser per input, 5 inputs total.
- **Debounce, per input:**
  - Stable level register plus a counter of width `$clog2(DEBOUNCE_CYCLES)`.
  - Counter clears whenever the synchronised value equals the stable level.
  - Otherwise the counter increments.
  - On reaching `DEBOUNCE_CYCLES-1` while still differing, the stable level toggles and the counter clears.
- **Press detection:** press = stable level rising 0→1. Releases produce no pulse.
- **Start:** `o_Game_Start` pulses one cycle per start press. No repeat.
- **Direction arbitration:**
  - At most one `o_*_Mvt` is high in any cycle.
  - Simultaneous direction presses resolve by priority Up > Down > Left > Right.
  - Losing presses are dropped, not queued.
- **Ownership:** the direction that last produced a press pulse is the "owner".
- **Repeat FSM** (only with `AUTO_REPEAT_EN`), states `IDLE`, `DELAY`, `REPEAT`, with one shared counter of width `$clog2(max(REPEAT_DELAY,REPEAT_RATE))`:
  - `IDLE` → `DELAY` on an accepted press: pulse the owner, clear the counter.
  - `DELAY`: counter reaches `REPEAT_DELAY-1` → pulse the owner, clear the counter, go to `REPEAT`.
  - `REPEAT`: counter reaches `REPEAT_RATE-1` → pulse the owner, clear the counter, stay in `REPEAT`.
  - In `DELAY` or `REPEAT`, owner's stable level falls → `IDLE` with no pulse; other held directions do not inherit ownership.
  - In `DELAY` or `REPEAT`, press of another direction → that direction becomes owner, pulses, counter clears, go to `DELAY`.
  - A repeat expiry and a new press in the same cycle → the new press wins; exactly one pulse, for the new owner.

## Timing
- **Reset:** all outputs 0; synchroniser flops, stable levels and counters 0; FSM in `IDLE`. Reset is asynchronous in both assertion and effect.
- **Press latency:** a raw input that goes high and stays high gives:
  - stable level high at rising edge `2+DEBOUNCE_CYCLES`, counting the first sampling edge as edge 1;
  - press pulse high at edge `3+DEBOUNCE_CYCLES`, for exactly one cycle.
- **Bounce filtering:** a glitch or bounce shorter than `DEBOUNCE_CYCLES` cycles at the synchroniser output produces no level change and no pulse.
- **Repeat spacing:** first repeat pulse is `REPEAT_DELAY` cycles after the press pulse; later repeats are every `REPEAT_RATE` cycles.
- **Release latency:** the same debounce latency applies. The repeat stops at the cycle the stable level falls.
- **Switch held through reset:** if a switch is high when reset is released, it is treated as a fresh press after full debounce latency.
- **Reset mid-repeat:** aborts immediately. No pulse is emitted in the cycle reset deasserts.

## Configuration
- Macro: `MOVE_AUTO_REPEAT_EN`.
- **Defined:** the repeat FSM is compiled in; behaviour is as described in Operation.
- **Undefined:**
  - No FSM or repeat counter is built.
  - Exactly one pulse per debounced press, with the same priority and drop rules.
  - `REPEAT_DELAY` and `REPEAT_RATE` are ignored.
  - `o_Any_Held` is unaffected.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=20`, `REPEAT_RATE=8`.
1. Up raised at edge 1 and held 10 cycles, macro off → single `o_Up_Mvt` pulse at edge 7. No other outputs toggle.
2. Right toggles high 3 cycles / low 3 cycles for 30 cycles, then stays low → zero pulses on all outputs.
3. Up and Left raised on the same edge → one `o_Up_Mvt` pulse at edge 7, no `o_Left_Mvt` pulse, `o_Any_Held`=1 from edge 7.
4. Macro on, Down held 60 cycles → `o_Down_Mvt` pulses at edges 7, 27, 35, 43, 51, 59. Pulses stop 6 cycles after release.
5. Macro on, Left held, then Right pressed while Left is in `REPEAT` → Right pulses, then repeats at +20, then every +8. No further Left pulses.
6. `i_Rst` asserted mid-`REPEAT` for 2 cycles with the switch still held → outputs 0 during reset, next pulse at edge 7 after reset release.
